// File: rtl/usb_uart_fifo_bridge.sv
// usb_uart_fifo_bridge
// Byte bridge between a user stream and the two pipes of a USB UART function.
// User bytes are buffered in a TX FIFO and released to the device-to-host pipe
// in batches. Release happens on a byte-count threshold, on a hold timeout, or
// on an explicit flush. Host bytes land in an RX FIFO. When the RX FIFO is full,
// the host is either backpressured or the byte is dropped and counted. In
// loopback mode, host bytes are steered into the TX FIFO instead of the RX FIFO.

// First-word-fall-through byte FIFO; the caller gates push/pop with full/empty.
module usb_uart_fifo_bridge_fifo #(
    parameter int DEPTH = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  logic [7:0]                 din_i,
    input  logic                       pop_i,
    output logic [7:0]                 dout_o,
    output logic [$clog2(DEPTH):0]     level_o,
    output logic                       full_o,
    output logic                       empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   level_q, level_d;

    // Next pointers and occupancy; pointers wrap naturally because DEPTH is 2^AW.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push_i) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop_i)  rd_ptr_d = rd_ptr_q + AW'(1);
        if (push_i && !pop_i)      level_d = level_q + (AW+1)'(1);
        else if (!push_i && pop_i) level_d = level_q - (AW+1)'(1);
    end

    // Storage write; contents need no reset since occupancy gates visibility.
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_ptr_q] <= din_i;
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    assign dout_o  = mem_q[rd_ptr_q];
    assign level_o = level_q;
    assign full_o  = (level_q == (AW+1)'(DEPTH));
    assign empty_o = (level_q == '0);
endmodule

module usb_uart_fifo_bridge #(
    parameter int TX_DEPTH   = 64,
    parameter int RX_DEPTH   = 64,
    parameter int TX_BATCH   = 1,
    parameter int TX_TIMEOUT = 48000,
    parameter int RX_DROP    = 0,
    parameter int OVF_W      = 8
) (
    input  logic                          clk_48mhz,
    input  logic                          reset,
    input  logic [7:0]                    tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic [7:0]                    rx_data,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    output logic [7:0]                    uart_in_data,
    output logic                          uart_in_valid,
    input  logic                          uart_in_ready,
    input  logic [7:0]                    uart_out_data,
    input  logic                          uart_out_valid,
    output logic                          uart_out_ready,
    input  logic                          flush,
    input  logic                          loopback,
    output logic [$clog2(TX_DEPTH):0]     tx_level,
    output logic [$clog2(RX_DEPTH):0]     rx_level,
    output logic [OVF_W-1:0]              rx_overflow
);
    localparam int TX_LW = $clog2(TX_DEPTH) + 1;
    localparam int TMR_W = (TX_TIMEOUT > 1) ? $clog2(TX_TIMEOUT) : 1;

    typedef enum logic [1:0] {IDLE, HOLD, DRAIN} state_t;

    state_t           state_q;
    logic [TMR_W-1:0] timer_q;
    logic [OVF_W-1:0] ovf_q;

    logic       tx_full, tx_empty, rx_full, rx_empty;
    logic       tx_push, tx_pop, rx_push, rx_pop, rx_drop;
    logic [7:0] tx_din;
    logic       hold_release;

    // In loopback the host pipe feeds the TX FIFO and the user side is stalled.
    assign tx_din   = loopback ? uart_out_data : tx_data;
    assign tx_push  = (loopback ? uart_out_valid : tx_valid) && !tx_full;
    assign tx_ready = !tx_full && !loopback;

    assign uart_in_valid = (state_q == DRAIN) && !tx_empty;
    assign tx_pop        = uart_in_valid && uart_in_ready;

    // Host pipe readiness: TX space in loopback, else RX space or always-on drop mode.
    assign uart_out_ready = loopback ? !tx_full : ((RX_DROP != 0) ? 1'b1 : !rx_full);
    assign rx_push        = !loopback && uart_out_valid && !rx_full;
    assign rx_drop        = !loopback && uart_out_valid && rx_full && (RX_DROP != 0);

    assign rx_valid = !rx_empty;
    assign rx_pop   = rx_valid && rx_ready;

    assign hold_release = (tx_level >= TX_LW'(TX_BATCH)) || flush ||
                          (timer_q == TMR_W'(TX_TIMEOUT - 1));

    usb_uart_fifo_bridge_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk     (clk_48mhz),
        .rst     (reset),
        .push_i  (tx_push),
        .din_i   (tx_din),
        .pop_i   (tx_pop),
        .dout_o  (uart_in_data),
        .level_o (tx_level),
        .full_o  (tx_full),
        .empty_o (tx_empty)
    );

    usb_uart_fifo_bridge_fifo #(.DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk     (clk_48mhz),
        .rst     (reset),
        .push_i  (rx_push),
        .din_i   (uart_out_data),
        .pop_i   (rx_pop),
        .dout_o  (rx_data),
        .level_o (rx_level),
        .full_o  (rx_full),
        .empty_o (rx_empty)
    );

    // TX release FSM: wait in HOLD to coalesce bytes, then drain until empty.
    always_ff @(posedge clk_48mhz or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            timer_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (tx_push) begin
                        state_q <= HOLD;
                        timer_q <= '0;
                    end
                end
                HOLD: begin
                    if (hold_release) state_q <= DRAIN;
                    else              timer_q <= timer_q + TMR_W'(1);
                end
                DRAIN: begin
                    if (tx_pop && (tx_level == TX_LW'(1)) && !tx_push) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Saturating count of host bytes discarded because the RX FIFO was full.
    always_ff @(posedge clk_48mhz or posedge reset) begin
        if (reset)                       ovf_q <= '0;
        else if (rx_drop && ovf_q != '1) ovf_q <= ovf_q + OVF_W'(1);
    end

    assign rx_overflow = ovf_q;
endmodule

// File: tb/tb_usb_uart_fifo_bridge.sv
// Directed bench for usb_uart_fifo_bridge with a byte scoreboard on both outputs.
module tb_usb_uart_fifo_bridge;
    localparam int RXD = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] tx_data, rx_data, uart_in_data, uart_out_data;
    logic       tx_valid, tx_ready, rx_valid, rx_ready;
    logic       uart_in_valid, uart_in_ready, uart_out_valid, uart_out_ready;
    logic       flush, loopback;
    logic [2:0] tx_level, rx_level;
    logic [1:0] rx_overflow;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int c0;
    int ovf_model = 0;
    bit tx_acc, host_acc;
    logic [7:0] tx_exp[$];
    logic [7:0] rx_exp[$];

    usb_uart_fifo_bridge #(
        .TX_DEPTH(4), .RX_DEPTH(RXD), .TX_BATCH(4), .TX_TIMEOUT(16),
        .RX_DROP(1), .OVF_W(2)
    ) dut (
        .clk_48mhz      (clk),
        .reset          (reset),
        .tx_data        (tx_data),
        .tx_valid       (tx_valid),
        .tx_ready       (tx_ready),
        .rx_data        (rx_data),
        .rx_valid       (rx_valid),
        .rx_ready       (rx_ready),
        .uart_in_data   (uart_in_data),
        .uart_in_valid  (uart_in_valid),
        .uart_in_ready  (uart_in_ready),
        .uart_out_data  (uart_out_data),
        .uart_out_valid (uart_out_valid),
        .uart_out_ready (uart_out_ready),
        .flush          (flush),
        .loopback       (loopback),
        .tx_level       (tx_level),
        .rx_level       (rx_level),
        .rx_overflow    (rx_overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: observe handshakes at the falling edge, then step past the rising edge.
    task automatic tick();
        bit rx_full_pre;
        @(negedge clk);
        if (!reset) begin
            rx_full_pre = (rx_exp.size() >= RXD);
            if (uart_in_valid && uart_in_ready) begin
                n_tests++;
                assert (tx_exp.size() != 0) else begin
                    n_fail++;
                    $error("FAIL uart_in_extra: observed byte %0h expected none", uart_in_data);
                end
                if (tx_exp.size() != 0) check("uart_in_data", uart_in_data, tx_exp.pop_front());
            end
            if (rx_valid && rx_ready) begin
                n_tests++;
                assert (rx_exp.size() != 0) else begin
                    n_fail++;
                    $error("FAIL rx_extra: observed byte %0h expected none", rx_data);
                end
                if (rx_exp.size() != 0) check("rx_data", rx_data, rx_exp.pop_front());
            end
            if (tx_valid && tx_ready) begin
                tx_exp.push_back(tx_data);
                tx_acc = 1'b1;
            end
            if (uart_out_valid && uart_out_ready) begin
                host_acc = 1'b1;
                if (loopback)          tx_exp.push_back(uart_out_data);
                else if (!rx_full_pre) rx_exp.push_back(uart_out_data);
                else if (ovf_model < 3) ovf_model++;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic send_tx(input logic [7:0] b);
        int n = 0;
        tx_valid = 1'b1;
        tx_data  = b;
        tx_acc   = 1'b0;
        do begin tick(); n++; end while (!tx_acc && n < 20);
        check("tx_accept", tx_acc, 1);
        tx_valid = 1'b0;
    endtask

    task automatic send_host(input logic [7:0] b);
        int n = 0;
        uart_out_valid = 1'b1;
        uart_out_data  = b;
        host_acc       = 1'b0;
        do begin tick(); n++; end while (!host_acc && n < 20);
        check("host_accept", host_acc, 1);
        uart_out_valid = 1'b0;
    endtask

    task automatic wait_tx_empty(input int budget);
        int n = 0;
        while ((tx_exp.size() != 0 || uart_in_valid) && n < budget) begin tick(); n++; end
        check("tx_drain_done", tx_exp.size(), 0);
        check("tx_drain_level", tx_level, 0);
    endtask

    initial begin
        bit e;
        reset = 1'b1; loopback = 1'b1; flush = 1'b0;
        tx_data = 8'h00; tx_valid = 1'b0; rx_ready = 1'b0;
        uart_in_ready = 1'b0; uart_out_data = 8'h00; uart_out_valid = 1'b0;

        // Reset state, with loopback high then low
        tick(); tick();
        check("rst_uart_in_valid", uart_in_valid, 0);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_tx_level", tx_level, 0);
        check("rst_rx_level", rx_level, 0);
        check("rst_tx_ready_lb", tx_ready, 0);
        check("rst_uart_out_ready_lb", uart_out_ready, 1);
        loopback = 1'b0;
        #1;
        check("rst_tx_ready", tx_ready, 1);
        check("rst_uart_out_ready", uart_out_ready, 1);
        check("rst_overflow", rx_overflow, 0);
        reset = 1'b0;
        tick();

        // Timeout release: three bytes, valid rises 16 cycles after HOLD entry
        uart_in_ready = 1'b1;
        send_tx(8'h41);
        c0 = cyc;
        send_tx(8'h42);
        send_tx(8'h43);
        while (cyc <= c0 + 20) begin
            e = (cyc >= c0 + 16) && (cyc <= c0 + 18);
            check("timeout_valid", uart_in_valid, e);
            if (cyc == c0 + 16) check("timeout_level", tx_level, 3);
            tick();
        end
        check("timeout_done_level", tx_level, 0);

        // Batch release: valid the cycle after tx_level reaches 4
        send_tx(8'h10);
        c0 = cyc;
        send_tx(8'h11);
        send_tx(8'h12);
        send_tx(8'h13);
        check("batch_level4", tx_level, 4);
        check("batch_not_yet", uart_in_valid, 0);
        tick();
        check("batch_valid", uart_in_valid, 1);
        wait_tx_empty(10);
        check("batch_idle_valid", uart_in_valid, 0);

        // Full TX FIFO: fifth byte held by the source, then drained
        uart_in_ready = 1'b0;
        send_tx(8'h60);
        check("full_idle_to_hold", uart_in_valid, 0);
        send_tx(8'h61);
        send_tx(8'h62);
        send_tx(8'h63);
        check("full_tx_ready", tx_ready, 0);
        check("full_tx_level", tx_level, 4);
        tx_valid = 1'b1;
        tx_data  = 8'h64;
        tx_acc   = 1'b0;
        tick(); tick();
        check("full_held_ready", tx_ready, 0);
        check("full_held_level", tx_level, 4);
        check("full_head_valid", uart_in_valid, 1);
        check("full_head_data", uart_in_data, 8'h60);
        check("full_fifth_held", tx_acc, 0);
        flush = 1'b1;
        uart_in_ready = 1'b1;
        for (int i = 0; i < 10 && !tx_acc; i++) tick();
        check("full_fifth_accept", tx_acc, 1);
        tx_valid = 1'b0;
        wait_tx_empty(20);
        flush = 1'b0;

        // Flush releases a single held byte early
        send_tx(8'h77);
        check("flush_hold0", uart_in_valid, 0);
        tick();
        check("flush_hold1", uart_in_valid, 0);
        flush = 1'b1;
        tick();
        check("flush_drain", uart_in_valid, 1);
        check("flush_data", uart_in_data, 8'h77);
        flush = 1'b0;
        tick();
        check("flush_done_level", tx_level, 0);
        check("flush_done_valid", uart_in_valid, 0);

        // RX drop mode: six host bytes into a 4-deep RX FIFO
        for (int i = 0; i < 6; i++) send_host(8'hA0 + 8'(i));
        check("drop_rx_level", rx_level, 4);
        check("drop_overflow", rx_overflow, 2);
        check("drop_rx_valid", rx_valid, 1);
        check("drop_rx_head", rx_data, 8'hA0);
        check("drop_ready_full", uart_out_ready, 1);
        send_host(8'hB0);
        send_host(8'hB1);
        check("drop_overflow_sat", rx_overflow, 3);
        check("drop_overflow_model", rx_overflow, ovf_model);

        // Loopback: host bytes return to host, RX untouched but readable
        loopback = 1'b1;
        #1;
        check("lb_tx_ready", tx_ready, 0);
        check("lb_uart_out_ready", uart_out_ready, 1);
        send_host(8'h55);
        send_host(8'hAA);
        wait_tx_empty(40);
        check("lb_rx_level", rx_level, 4);
        check("lb_overflow", rx_overflow, 3);
        check("lb_tx_ready_after", tx_ready, 0);
        rx_ready = 1'b1;
        tick(); tick();
        rx_ready = 1'b0;
        check("lb_rx_read_level", rx_level, 2);
        check("lb_rx_head", rx_data, 8'hA2);
        loopback = 1'b0;

        // Reset mid-transfer: TX holding 3 bytes, RX holding 2
        uart_in_ready = 1'b0;
        send_tx(8'h31);
        send_tx(8'h32);
        send_tx(8'h33);
        check("pre_rst_tx_level", tx_level, 3);
        check("pre_rst_rx_level", rx_level, 2);
        reset = 1'b1;
        #1;
        tx_exp.delete();
        rx_exp.delete();
        ovf_model = 0;
        check("arst_tx_level", tx_level, 0);
        check("arst_rx_level", rx_level, 0);
        check("arst_overflow", rx_overflow, 0);
        check("arst_rx_valid", rx_valid, 0);
        check("arst_uart_in_valid", uart_in_valid, 0);
        check("arst_tx_ready", tx_ready, 1);
        check("arst_uart_out_ready", uart_out_ready, 1);
        tick(); tick();
        reset = 1'b0;
        tick();
        check("post_rst_tx_level", tx_level, 0);
        check("post_rst_rx_valid", rx_valid, 0);
        check("post_rst_uart_in_valid", uart_in_valid, 0);

        // After reset the FSM starts from IDLE with a cleared timer
        uart_in_ready = 1'b1;
        send_tx(8'h99);
        c0 = cyc;
        while (cyc <= c0 + 18) begin
            e = (cyc == c0 + 16);
            check("post_rst_timeout_valid", uart_in_valid, e);
            tick();
        end
        check("post_rst_final_level", tx_level, 0);
        check("post_rst_scoreboard", tx_exp.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/usb_uart_fifo_bridge.md
USB_UART_FIFO_BRIDGE -- requirements
Module: usb_uart_fifo_bridge

Interface
REQ-001 SHALL have parameter TX_DEPTH, default 64: TX FIFO entries, power of two, >=2.
REQ-002 SHALL have parameter RX_DEPTH, default 64: RX FIFO entries, power of two, >=2.
REQ-003 SHALL have parameter TX_BATCH, default 1: TX byte count that releases a held batch, 1..TX_DEPTH.
REQ-004 SHALL have parameter TX_TIMEOUT, default 48000: HOLD cycles before forced release, >=1.
REQ-005 SHALL have parameter RX_DROP, default 0: 0 = backpressure host on RX full; 1 = always accept, drop on full.
REQ-006 SHALL have parameter OVF_W, default 8: width of the overflow counter.
REQ-007 clk_48mhz  input  1  sole clock; all state on rising edge.
REQ-008 reset  input  1  asynchronous, active-high reset.
REQ-009 tx_data/tx_valid/tx_ready  input/input/output  8/1/1  user bytes toward host.
REQ-010 rx_data/rx_valid/rx_ready  output/output/input  8/1/1  host bytes toward user.
REQ-011 uart_in_data/uart_in_valid/uart_in_ready  output/output/input  8/1/1  to USB UART device-to-host pipe.
REQ-012 uart_out_data/uart_out_valid/uart_out_ready  input/input/output  8/1/1  from USB UART host-to-device pipe.
REQ-013 flush  input  1  force immediate release of held TX bytes.
REQ-014 loopback  input  1  route host bytes back to host.
REQ-015 tx_level  output  $clog2(TX_DEPTH)+1  TX FIFO occupancy.
REQ-016 rx_level  output  $clog2(RX_DEPTH)+1  RX FIFO occupancy.
REQ-017 rx_overflow  output  OVF_W  count of dropped host bytes, saturating.

Function
REQ-018 All handshakes SHALL transfer exactly on cycles where valid and ready are both high; a valid, once asserted, SHALL hold with stable data until accepted.
REQ-019 FIFOs SHALL be first-word-fall-through; rx_data/uart_in_data SHALL show the head entry whenever the matching valid is high.
REQ-020 TX FIFO push source SHALL be tx_* when loopback=0, uart_out_* when loopback=1; tx_ready SHALL be 0 while loopback=1.
REQ-021 tx_ready SHALL equal (TX not full) and not loopback; simultaneous push and pop on a full FIFO SHALL NOT be accepted for push.
REQ-022 TX drain FSM SHALL have states IDLE, HOLD, DRAIN; uart_in_valid SHALL be high only in DRAIN with FIFO non-empty.
REQ-023 IDLE->HOLD SHALL occur the cycle after the first push into an empty TX FIFO; HOLD timer SHALL clear on HOLD entry.
REQ-024 HOLD->DRAIN SHALL occur when tx_level>=TX_BATCH, flush=1, or the timer reaches TX_TIMEOUT-1, whichever first; with TX_BATCH=1, HOLD SHALL last exactly one cycle.
REQ-025 DRAIN->IDLE SHALL occur when a pop leaves the FIFO empty with no simultaneous push; otherwise DRAIN SHALL continue.
REQ-026 With loopback=0, uart_out_ready SHALL be (RX not full) for RX_DROP=0 and constant 1 for RX_DROP=1.
REQ-027 With RX_DROP=1, a host byte arriving with RX full SHALL be discarded and rx_overflow SHALL increment, holding at 2^OVF_W-1.
REQ-028 With loopback=1, uart_out_ready SHALL be (TX not full), the RX FIFO SHALL receive nothing, and its existing contents SHALL remain readable.
REQ-029 tx_level/rx_level SHALL reflect post-edge occupancy; simultaneous push and pop SHALL leave level unchanged; pointers SHALL wrap modulo depth.
REQ-030 Changing loopback SHALL take effect the same cycle with no byte lost or duplicated.

Reset
REQ-031 Reset SHALL empty both FIFOs, set FSM to IDLE, clear the HOLD timer and rx_overflow.
REQ-032 During and after reset: uart_in_valid=0, rx_valid=0, tx_level=0, rx_level=0, tx_ready=!loopback, uart_out_ready=1.
REQ-033 Reset asserted mid-transfer SHALL discard all buffered bytes; no partial byte SHALL appear after deassertion.

Verification
REQ-034 TX_BATCH=4, TX_TIMEOUT=16: push 0x41,0x42,0x43 -> uart_in_valid rises 16 cycles after HOLD entry; 0x41,0x42,0x43 out in order.
REQ-035 TX_BATCH=4: push 0x10..0x13 back-to-back, uart_in_ready=1 -> uart_in_valid high the cycle after tx_level=4; four bytes, FSM back to IDLE.
REQ-036 TX_DEPTH=4, uart_in_ready=0: push 5 bytes -> tx_ready=0 after 4th, tx_level=4, 5th held by source; flush -> all 5 delivered in order.
REQ-037 RX_DROP=1, RX_DEPTH=4, rx_ready=0: host sends 6 bytes -> rx_level=4, rx_overflow=2, rx_data=first byte.
REQ-038 loopback=1: host sends 0x55,0xAA -> uart_in emits 0x55,0xAA, rx_level unchanged, tx_ready=0.
REQ-039 Reset pulse with TX holding 3 bytes and rx_level=2 -> both levels 0, all valids 0, rx_overflow=0, FSM IDLE.
